// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core control units / shared RAM and the arbiter.
// slave  : arbiter side (consumes requests, drives memory port and acks).
// master : environment side (cores plus the memory model).
interface mem_arbiter_if #(
  parameter int NUM_CORES  = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_CORES-1:0]            req;
  logic [NUM_CORES-1:0]            we;
  logic [NUM_CORES*ADDR_WIDTH-1:0] addr;
  logic [NUM_CORES*DATA_WIDTH-1:0] wdata;
  logic [NUM_CORES-1:0]            ack;
  logic [DATA_WIDTH-1:0]           rdata;
  logic                            mem_en;
  logic                            mem_we;
  logic [ADDR_WIDTH-1:0]           mem_addr;
  logic [DATA_WIDTH-1:0]           mem_wdata;
  logic [DATA_WIDTH-1:0]           mem_rdata;
  logic                            busy;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between NUM_CORES
// core control units. One access in flight at a time: IDLE (arbitrate),
// ISSUE (drive RAM), RESP (sample read data), with the ack landing in the
// next IDLE cycle so back-to-back accesses take 3 cycles each.
module mem_arbiter #(
  parameter int NUM_CORES  = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int              LG_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [LG_W-1:0] LAST_CORE = LG_W'(NUM_CORES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                 state_q, state_d;

  logic [LG_W-1:0]        grant_q, grant_d;
  logic [LG_W-1:0]        last_grant_q, last_grant_d;
  logic                   we_q, we_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [NUM_CORES-1:0]   ack_q, ack_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;

  logic [NUM_CORES-1:0]   eligible;
  logic                   win_found;
  logic [LG_W-1:0]        win_idx;
  logic [LG_W-1:0]        cand;
  logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_CORES];
  logic [DATA_WIDTH-1:0]  wdata_arr [NUM_CORES];

  // The core being acked this cycle is still holding req; mask it so it is
  // not immediately re-granted on a request it is about to drop.
  assign eligible = bus.req & ~ack_q;

  // Split the flat per-core address / write-data buses into indexable arrays.
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      addr_arr[i]  = bus.addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_arr[i] = bus.wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Round-robin pick: walk from last_grant+1, wrapping at NUM_CORES, first hit wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_grant_q;
    cand      = last_grant_q;
    for (int i = 0; i < NUM_CORES; i++) begin
      cand = (cand == LAST_CORE) ? '0 : cand + LG_W'(1);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: ISSUE and RESP always last exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: the RAM is only enabled in ISSUE; busy covers ISSUE and RESP.
  always_comb begin
    bus.mem_en = 1'b0;
    bus.mem_we = 1'b0;
    bus.busy   = 1'b0;
    case (state_q)
      ISSUE: begin
        bus.mem_en = 1'b1;
        bus.mem_we = we_q;
        bus.busy   = 1'b1;
      end
      RESP: begin
        bus.busy   = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next-state: latch the winner's request at arbitration so later
  // input changes cannot disturb the access in flight; ack/rdata out of RESP.
  always_comb begin
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    ack_d        = '0;
    rdata_d      = rdata_q;
    if (state_q == IDLE && win_found) begin
      grant_d      = win_idx;
      last_grant_d = win_idx;
      we_d         = bus.we[win_idx];
      addr_d       = addr_arr[win_idx];
      wdata_d      = wdata_arr[win_idx];
    end
    if (state_q == RESP) begin
      ack_d[grant_q] = 1'b1;
      if (!we_q) begin
        rdata_d = bus.mem_rdata;
      end
    end
  end

  // Datapath registers; reset aborts any access in flight (no ack, rdata cleared)
  // and gives core 0 first priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q      <= '0;
      last_grant_q <= LAST_CORE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ack_q        <= '0;
      rdata_q      <= '0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle table for single read, reset and
// full contention, then hand-written sequences for write/read ordering,
// fairness with ack masking, reset during RESP and input latching.
module tb_mem_arbiter;

  localparam int NC = 4;
  localparam int AW = 16;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset;

  mem_arbiter_if #(.NUM_CORES(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_arbiter #(.NUM_CORES(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Single-port RAM model: registered read, data valid the cycle after mem_en.
  logic [DW-1:0] ram [0:65535];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (bus.mem_en && bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= ram[bus.mem_addr];
  end

  typedef struct packed {
    logic          rst;
    logic [NC-1:0] req;
    logic [NC-1:0] ack;
    logic          busy;
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata;
  } vec_t;

  vec_t vecs [20];
  int   tests;
  int   fails;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%0h expected=0x%0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    step();
    pl_en   = 1'b0;
  endtask

  task automatic set_core(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
    bus.addr[c*AW +: AW]  = a;
    bus.wdata[c*DW +: DW] = d;
    bus.we[c]             = w;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tests     = 0;
    fails     = 0;
    reset     = 1'b1;
    pl_en     = 1'b0;
    pl_addr   = '0;
    pl_data   = '0;
    bus.req   = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;

    //            rst   req      ack      busy  en    we    addr      rdata
    vecs[0]  = '{1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00};
    vecs[1]  = '{1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0, 16'h0010, 8'h00};
    vecs[2]  = '{1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 16'h0010, 8'h00};
    vecs[3]  = '{1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0, 16'h0010, 8'hA5};
    vecs[4]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 16'h0010, 8'hA5};
    vecs[5]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 16'h0010, 8'hA5};
    vecs[6]  = '{1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00};
    vecs[7]  = '{1'b0, 4'b1111, 4'b0000, 1'b1, 1'b1, 1'b0, 16'h0100, 8'h00};
    vecs[8]  = '{1'b0, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 16'h0100, 8'h00};
    vecs[9]  = '{1'b0, 4'b1111, 4'b0001, 1'b0, 1'b0, 1'b0, 16'h0100, 8'hC0};
    vecs[10] = '{1'b0, 4'b1110, 4'b0000, 1'b1, 1'b1, 1'b0, 16'h0101, 8'hC0};
    vecs[11] = '{1'b0, 4'b1110, 4'b0000, 1'b1, 1'b0, 1'b0, 16'h0101, 8'hC0};
    vecs[12] = '{1'b0, 4'b1110, 4'b0010, 1'b0, 1'b0, 1'b0, 16'h0101, 8'hC1};
    vecs[13] = '{1'b0, 4'b1100, 4'b0000, 1'b1, 1'b1, 1'b0, 16'h0010, 8'hC1};
    vecs[14] = '{1'b0, 4'b1100, 4'b0000, 1'b1, 1'b0, 1'b0, 16'h0010, 8'hC1};
    vecs[15] = '{1'b0, 4'b1100, 4'b0100, 1'b0, 1'b0, 1'b0, 16'h0010, 8'hA5};
    vecs[16] = '{1'b0, 4'b1000, 4'b0000, 1'b1, 1'b1, 1'b0, 16'h0103, 8'hA5};
    vecs[17] = '{1'b0, 4'b1000, 4'b0000, 1'b1, 1'b0, 1'b0, 16'h0103, 8'hA5};
    vecs[18] = '{1'b0, 4'b1000, 4'b1000, 1'b0, 1'b0, 1'b0, 16'h0103, 8'hC3};
    vecs[19] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 16'h0103, 8'hC3};

    repeat (2) step();
    preload(16'h0100, 8'hC0);
    preload(16'h0101, 8'hC1);
    preload(16'h0010, 8'hA5);
    preload(16'h0103, 8'hC3);

    check("rst_busy",   32'(bus.busy),      32'h0);
    check("rst_ack",    32'(bus.ack),       32'h0);
    check("rst_mem_en", 32'(bus.mem_en),    32'h0);
    check("rst_mem_we", 32'(bus.mem_we),    32'h0);
    check("rst_wdata",  32'(bus.mem_wdata), 32'h0);

    set_core(0, 16'h0100, 8'h00, 1'b0);
    set_core(1, 16'h0101, 8'h00, 1'b0);
    set_core(2, 16'h0010, 8'h00, 1'b0);
    set_core(3, 16'h0103, 8'h00, 1'b0);
    reset = 1'b0;

    // Cycle table: single read by core 2, reset, then full contention.
    for (int i = 0; i < 20; i++) begin
      reset   = vecs[i].rst;
      bus.req = vecs[i].req;
      check($sformatf("vec%0d_ack", i),   32'(bus.ack),      32'(vecs[i].ack));
      check($sformatf("vec%0d_busy", i),  32'(bus.busy),     32'(vecs[i].busy));
      check($sformatf("vec%0d_en", i),    32'(bus.mem_en),   32'(vecs[i].en));
      check($sformatf("vec%0d_we", i),    32'(bus.mem_we),   32'(vecs[i].we));
      check($sformatf("vec%0d_addr", i),  32'(bus.mem_addr), 32'(vecs[i].addr));
      check($sformatf("vec%0d_rdata", i), 32'(bus.rdata),    32'(vecs[i].rdata));
      step();
    end

    // Write by core 1, then read of the same word by core 3.
    set_core(1, 16'h0200, 8'h3C, 1'b1);
    bus.req = 4'b0010;
    check("wr_idle_we", 32'(bus.mem_we), 32'h0);
    step();
    check("wr_issue_en",    32'(bus.mem_en),    32'h1);
    check("wr_issue_we",    32'(bus.mem_we),    32'h1);
    check("wr_issue_addr",  32'(bus.mem_addr),  32'h0200);
    check("wr_issue_wdata", 32'(bus.mem_wdata), 32'h3C);
    step();
    check("wr_resp_we", 32'(bus.mem_we), 32'h0);
    step();
    check("wr_ack",       32'(bus.ack),   32'b0010);
    check("wr_rdata_keep", 32'(bus.rdata), 32'hC3);
    set_core(3, 16'h0200, 8'h00, 1'b0);
    bus.req = 4'b1010;
    step();
    bus.req = 4'b1000;
    set_core(1, 16'h0101, 8'h00, 1'b0);
    check("rd_issue_en",   32'(bus.mem_en),   32'h1);
    check("rd_issue_we",   32'(bus.mem_we),   32'h0);
    check("rd_issue_addr", 32'(bus.mem_addr), 32'h0200);
    step();
    step();
    check("rd_ack",   32'(bus.ack),   32'b1000);
    check("rd_rdata", 32'(bus.rdata), 32'h3C);
    bus.req = 4'b0000;
    step();

    // Core 0 keeps re-requesting, core 1 holds req: grants alternate 0,1,0,1.
    bus.req = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("fair%0d_en", k),   32'(bus.mem_en),   32'h1);
      check($sformatf("fair%0d_addr", k), 32'(bus.mem_addr), 32'h0100 + 32'(k % 2));
      step();
      step();
      check($sformatf("fair%0d_ack", k),  32'(bus.ack),      32'h1 << (k % 2));
    end
    bus.req = 4'b0000;
    check("fair_rdata", 32'(bus.rdata), 32'hC1);
    step();

    // Reset asserted in RESP of a core 3 read.
    set_core(3, 16'h0200, 8'h00, 1'b0);
    bus.req = 4'b1000;
    step();
    check("rr_issue_addr", 32'(bus.mem_addr), 32'h0200);
    step();
    check("rr_resp_busy", 32'(bus.busy), 32'h1);
    reset   = 1'b1;
    bus.req = 4'b1001;
    step();
    reset = 1'b0;
    check("rr_busy",  32'(bus.busy),   32'h0);
    check("rr_ack",   32'(bus.ack),    32'h0);
    check("rr_rdata", 32'(bus.rdata),  32'h00);
    check("rr_en",    32'(bus.mem_en), 32'h0);
    step();
    check("rr_grant_en",   32'(bus.mem_en),   32'h1);
    check("rr_grant_addr", 32'(bus.mem_addr), 32'h0100);
    step();
    step();
    check("rr_ack0",   32'(bus.ack),   32'b0001);
    check("rr_rdata0", 32'(bus.rdata), 32'hC0);
    bus.req = 4'b0000;
    step();

    // Core 0 changes its address right after being granted.
    set_core(0, 16'h0001, 8'h00, 1'b0);
    bus.req = 4'b0001;
    step();
    set_core(0, 16'h0FFF, 8'h00, 1'b0);
    check("latch_issue_en",   32'(bus.mem_en),   32'h1);
    check("latch_issue_addr", 32'(bus.mem_addr), 32'h0001);
    step();
    check("latch_resp_addr", 32'(bus.mem_addr), 32'h0001);
    step();
    check("latch_ack", 32'(bus.ack), 32'b0001);
    bus.req = 4'b0000;
    step();
    check("latch_idle_ack", 32'(bus.ack), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
